// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stage enable/flush sequencing for the 5-stage 16-bit CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_opcode,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic [3:0]  ex_opcode,
    input  logic [3:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt
);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_sll  = 4'd4;
    localparam logic [3:0] c_op_srl  = 4'd5;
    localparam logic [3:0] c_op_sra  = 4'd6;
    localparam logic [3:0] c_op_rl   = 4'd7;
    localparam logic [3:0] c_op_lw   = 4'd8;
    localparam logic [3:0] c_op_sw   = 4'd9;
    localparam logic [3:0] c_op_jr   = 4'd14;
    localparam logic [3:0] c_op_exec = 4'd15;

    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES);
    localparam logic [7:0] c_timeout    = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_flush_cnt, w_flush_cnt_nxt;
    logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        r_ret_flush, w_ret_flush_nxt;
    logic        r_mem_timeout;
    logic [15:0] r_stall_cnt;

    logic w_rs_used, w_rt_used, w_load_use, w_mem_stall;
    logic w_hold, w_release, w_in_flush;

    always_comb begin
        w_rs_used = 1'b0;
        w_rt_used = 1'b0;
        case (id_opcode)
            c_op_add, c_op_sub, c_op_and, c_op_or: begin
                w_rs_used = 1'b1;
                w_rt_used = 1'b1;
            end
            c_op_sw: begin
                w_rs_used = 1'b1;
                w_rt_used = 1'b1;
            end
            c_op_sll, c_op_srl, c_op_sra, c_op_rl,
            c_op_lw, c_op_jr, c_op_exec: w_rs_used = 1'b1;
            default: ;
        endcase
    end

    assign w_load_use  = (ex_opcode == c_op_lw) && (ex_rd != 4'd0) &&
                         ((w_rs_used && (ex_rd == id_rs)) ||
                          (w_rt_used && (ex_rd == id_rt)));
    assign w_mem_stall = mem_access && !dmem_ready;

    // MEM_WAIT is left only when the memory signals completion.
    assign w_hold     = (r_state == MEM_WAIT) ? !dmem_ready : w_mem_stall;
    assign w_release  = (r_state == MEM_WAIT) && dmem_ready;
    assign w_in_flush = (r_state == FLUSH) || (w_release && r_ret_flush);

    always_comb begin
        pc_en           = 1'b1;
        ifid_en         = 1'b1;
        idex_en         = 1'b1;
        exmem_en        = 1'b1;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        memwb_flush     = 1'b0;
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_ret_flush_nxt = r_ret_flush;

        if (w_hold) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            if (r_state != MEM_WAIT) begin
                w_state_nxt     = MEM_WAIT;
                w_ret_flush_nxt = (r_state == FLUSH);
                w_wait_cnt_nxt  = 8'd1;
            end else if (r_wait_cnt != 8'hFF) begin
                w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
        end else begin
            w_wait_cnt_nxt = 8'd0;
            w_state_nxt    = w_in_flush ? FLUSH : RUN;
            if (w_in_flush) begin
                ifid_flush = 1'b1;
            end
            if (ex_redirect) begin
                ifid_flush      = 1'b1;
                idex_flush      = 1'b1;
                w_flush_cnt_nxt = c_flush_load;
                w_state_nxt     = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
            end else if (r_state == FLUSH) begin
                w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                if (r_flush_cnt <= 3'd1) begin
                    w_state_nxt = RUN;
                end
            end else if (!w_in_flush && w_load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_flush_cnt   <= 3'd0;
            r_wait_cnt    <= 8'd0;
            r_ret_flush   <= 1'b0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_ret_flush <= w_ret_flush_nxt;
            if (w_hold && (w_wait_cnt_nxt >= c_timeout)) begin
                r_mem_timeout <= 1'b1;
            end
            if (!pc_en && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Scoreboarded random test of hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int FC = 2;
    localparam int MT = 4;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4,  OP_SRL = 4'd5,  OP_SRA = 4'd6,  OP_RL   = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8,  OP_SW  = 4'd9,  OP_LLB = 4'd11, OP_JR   = 4'd14;
    localparam logic [3:0] OP_EXEC = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  id_opcode = '0, id_rs = '0, id_rt = '0, ex_opcode = '0, ex_rd = '0;
    logic        ex_redirect = 1'b0, mem_access = 1'b0, dmem_ready = 1'b1;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush;
    logic        mem_timeout;
    logic [15:0] stall_cnt;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ctl;   // {pc, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, memwb_fl}
        logic        tmo;
        logic [15:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Model: remaining flush cycles, whether a memory access is outstanding,
    // how long it has been outstanding, sticky timeout, stalled-cycle count.
    int m_flush_left = 0;
    bit m_waiting = 0;
    int m_wait = 0;
    bit m_tmo = 0;
    int m_scnt = 0;

    function automatic bit uses_rs(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SRA, OP_RL,
                          OP_LW, OP_SW, OP_JR, OP_EXEC};
    endfunction

    function automatic bit uses_rt(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW};
    endfunction

    task automatic step(input bit rstn, input logic [3:0] iop, irs, irt, eop, erd,
                        input bit redir, macc, drdy);
        exp_t e;
        bit pc, ifen, idexen, exen, iffl, idfl, mwfl, stall, rel, fl, lu;
        @(posedge clk);
        #1;
        rst_n = rstn; id_opcode = iop; id_rs = irs; id_rt = irt;
        ex_opcode = eop; ex_rd = erd; ex_redirect = redir;
        mem_access = macc; dmem_ready = drdy;
        if (!rstn) begin
            m_flush_left = 0; m_waiting = 0; m_wait = 0; m_tmo = 0; m_scnt = 0;
            e.ctl = 7'b0000111; e.tmo = 1'b0; e.scnt = 16'd0;
        end else begin
            e.tmo = m_tmo;
            e.scnt = 16'(m_scnt);
            pc = 1; ifen = 1; idexen = 1; exen = 1; iffl = 0; idfl = 0; mwfl = 0;
            stall = m_waiting ? !drdy : (macc && !drdy);
            if (stall) begin
                pc = 0; ifen = 0; idexen = 0; exen = 0; mwfl = 1;
                m_wait = m_waiting ? ((m_wait < 255) ? m_wait + 1 : 255) : 1;
                m_waiting = 1;
                if (m_wait >= MT) m_tmo = 1;
            end else begin
                rel = m_waiting;
                m_waiting = 0;
                m_wait = 0;
                fl = (m_flush_left > 0);
                lu = (eop == OP_LW) && (erd != 0) &&
                     ((uses_rs(iop) && erd == irs) || (uses_rt(iop) && erd == irt));
                if (fl) iffl = 1;
                if (redir) begin
                    iffl = 1; idfl = 1;
                    m_flush_left = FC;
                end else if (fl) begin
                    if (!rel) m_flush_left = m_flush_left - 1;
                end else if (lu) begin
                    pc = 0; ifen = 0; idfl = 1;
                end
            end
            if (!pc && m_scnt < 65535) m_scnt = m_scnt + 1;
            e.ctl = {pc, ifen, idexen, exen, iffl, idfl, mwfl};
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, OP_LLB, 4'd0, 4'd0, OP_ADD, 4'd0, 0, 0, 1);
    endtask

    initial begin
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush};
                checks += 3;
                if (got !== e.ctl) begin
                    failures++;
                    $display("FAIL ctl cycle=%0d got=%b exp=%b", cyc, got, e.ctl);
                end
                if (mem_timeout !== e.tmo) begin
                    failures++;
                    $display("FAIL mem_timeout cycle=%0d got=%b exp=%b", cyc, mem_timeout, e.tmo);
                end
                if (stall_cnt !== e.scnt) begin
                    failures++;
                    $display("FAIL stall_cnt cycle=%0d got=%0d exp=%0d", cyc, stall_cnt, e.scnt);
                end
            end
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit rb, redir, macc, drdy;
        logic [3:0] eop;
        // reset state
        step(0, OP_LLB, 0, 0, OP_ADD, 0, 0, 0, 1);
        step(0, OP_LLB, 0, 0, OP_ADD, 0, 0, 0, 1);
        idle(1);
        // load-use: LW r3 in EX, ADD r5,r3,r2 in ID; then ex_rd=0 variant
        step(1, OP_ADD, 4'd3, 4'd2, OP_LW, 4'd3, 0, 0, 1);
        idle(1);
        step(1, OP_ADD, 4'd0, 4'd2, OP_LW, 4'd0, 0, 0, 1);
        step(1, OP_SW, 4'd1, 4'd2, OP_LW, 4'd2, 0, 0, 1);
        step(1, OP_SLL, 4'd1, 4'd2, OP_LW, 4'd2, 0, 0, 1);
        // redirect pulse and flush window
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 1, 0, 1);
        idle(3);
        // 3-cycle memory wait then release
        for (int i = 0; i < 3; i++) step(1, OP_LLB, 0, 0, OP_ADD, 0, 0, 1, 0);
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 0, 1, 1);
        // redirect together with load-use
        step(1, OP_ADD, 4'd3, 4'd3, OP_LW, 4'd3, 1, 0, 1);
        idle(3);
        // memory stall with redirect, redirect honoured at release
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 1, 1, 0);
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 1, 1, 0);
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 1, 1, 1);
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 0, 1, 0);
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 0, 1, 1);
        idle(3);
        // timeout: six cycles waiting, flag sticks after release
        for (int i = 0; i < 6; i++) step(1, OP_LLB, 0, 0, OP_ADD, 0, 0, 1, 0);
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 0, 1, 1);
        idle(2);
        // reset in the middle of a flush
        step(1, OP_LLB, 0, 0, OP_ADD, 0, 1, 0, 1);
        step(0, OP_LLB, 0, 0, OP_ADD, 0, 0, 0, 1);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rb    = ($urandom_range(0, 199) != 0);
            redir = ($urandom_range(0, 5) == 0);
            eop   = ($urandom_range(0, 1) == 0) ? OP_LW : 4'($urandom_range(0, 15));
            macc  = m_waiting ? 1'b1 : ($urandom_range(0, 4) == 0);
            drdy  = ($urandom_range(0, 2) == 0);
            step(rb, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), eop, 4'($urandom_range(0, 3)), redir, macc, drdy);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 16-bit CPU (IF, ID, EX, MEM, WB).
- Generates per-stage enable and flush signals for load-use hazards, EX-resolved redirects (taken BR, JAL, JR, EXEC) and multi-cycle data-memory handshakes.
- Sits beside the decode control unit and drives the pipeline-register enables and the PC enable.
- Opcode encodings come from define.v.

Parameters:
- FLUSH_CYCLES, 1, extra cycles ifid_flush stays high after a redirect (covers the synchronous imem fetch latency); legal range 0..7.
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles before mem_timeout is set; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_opcode  in  4  opcode of the instruction in ID.
- id_rs  in  4  rs field in ID.
- id_rt  in  4  rt field in ID.
- ex_opcode  in  4  opcode of the instruction in EX.
- ex_rd  in  4  destination register of the instruction in EX.
- ex_redirect  in  1  EX is resolving a PC change this cycle (taken BR, JAL, JR, EXEC).
- mem_access  in  1  MEM stage holds LW or SW.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- idex_en  out  1  ID/EX register enable.
- exmem_en  out  1  EX/MEM register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load NOP into ID/EX.
- memwb_flush  out  1  load NOP into MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  16  saturating count of cycles with pc_en=0.

Behaviour:
- States: RUN, FLUSH, MEM_WAIT. Registers: state, flush_cnt[2:0], wait_cnt[7:0], ret_flush (1 bit), mem_timeout, stall_cnt.
- Outputs are combinational from state and the current inputs. Defaults: all *_en=1, all *_flush=0.
- Reset (rst_n low, asynchronous):
  - state=RUN; all counters, ret_flush and mem_timeout cleared.
  - While rst_n is low, the outputs are forced to: pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=idex_flush=memwb_flush=1.
  - Reset mid-stall or mid-flush abandons the sequence; the pipeline restarts from the PC reset value.
- Hazard terms:
  - mem_stall = mem_access & ~dmem_ready.
  - rs is used by ADD, SUB, AND, OR, SLL, SRL, SRA, RL, LW, SW, JR, EXEC.
  - rt is used by ADD, SUB, AND, OR, SW.
  - load_use = (ex_opcode==LW) & (ex_rd!=0) & ((rs used & ex_rd==id_rs) | (rt used & ex_rd==id_rt)).
  - Register 0 never creates a hazard.
- Priority within a cycle: mem_stall > ex_redirect > load_use.
- When mem_stall is high in any state:
  - All four enables are 0 and memwb_flush=1.
  - ex_redirect and load_use are ignored; EX is frozen, so they are re-presented after release.
  - From RUN or FLUSH, next state is MEM_WAIT. ret_flush is set to 1 if coming from FLUSH, otherwise 0. flush_cnt is frozen. wait_cnt is set to 1.
- RUN:
  - ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1. Next state is FLUSH with flush_cnt=FLUSH_CYCLES, or stays RUN if FLUSH_CYCLES=0.
  - load_use (no redirect): pc_en=0, ifid_en=0, idex_flush=1. This is a single-cycle bubble; state stays RUN.
- FLUSH:
  - ifid_flush=1, pc_en=1.
  - Each cycle flush_cnt decrements; at 1, next state is RUN.
  - A new ex_redirect reloads flush_cnt=FLUSH_CYCLES and asserts idex_flush=1.
  - load_use is ignored, because ID holds a flushed NOP.
- MEM_WAIT:
  - Outputs are the same as mem_stall.
  - wait_cnt increments, saturating at 255. When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set to 1 and held until reset.
  - On the cycle dmem_ready=1: the stall outputs are released (defaults) and wait_cnt clears. Next state is FLUSH if ret_flush=1, otherwise RUN.
  - ex_redirect or load_use present in the release cycle are handled as in RUN, on top of the restored FLUSH/RUN behaviour.
- stall_cnt increments on every cycle with pc_en=0 (reset excluded) and saturates at 16'hFFFF.

Test Plan:
- LW r3 in EX, ADD r5,r3,r2 in ID -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Same case with ex_rd=0 -> no stall.
- ex_redirect pulse, FLUSH_CYCLES=1 -> cycle 0: ifid_flush=idex_flush=1, pc_en=1. Cycle 1: ifid_flush=1 only. Cycle 2: RUN defaults.
- mem_access=1, dmem_ready low 3 cycles then high -> 3 cycles all enables 0 with memwb_flush=1, release on the 4th cycle; stall_cnt=3.
- Same cycle: ex_redirect + load_use -> redirect response only, no pc_en drop. mem_stall + ex_redirect -> stall only; the redirect is honoured in the release cycle.
- MEM_TIMEOUT=4, dmem_ready held low for 6 cycles -> mem_timeout rises when wait_cnt=4 and stays 1 after release. rst_n pulsed low mid-FLUSH -> forced reset outputs immediately, state RUN, counters 0.
